// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - segment bit indices, blank pattern and hex glyph decode
package sevenseg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-low glyphs, bit order gfedcba.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seven_segment_mux.sv
// rtl/seven_segment_mux.sv - multiplexed seven-segment driver with PWM dimming
// Display data is double-buffered so a new value only appears at a frame boundary.
module seven_segment_mux
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int BRIGHT_W    = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   digit_point,
   input  logic                    load,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [7:0]              segment,
   output logic                    frame_start
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;
   logic [BRIGHT_W-1:0]   pwm_cnt;
   logic                  slot_end;
   logic                  wrap;

   logic [3:0]            in_nib   [NUM_DIGITS];
   logic [3:0]            pend_nib [NUM_DIGITS];
   logic [3:0]            act_nib  [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] pend_en;
   logic [NUM_DIGITS-1:0] pend_pt;
   logic [NUM_DIGITS-1:0] act_en;
   logic [NUM_DIGITS-1:0] act_pt;
   logic                  pend_valid;

   logic                  lit;
   logic [NUM_DIGITS-1:0] anode_nxt;
   logic [7:0]            segment_nxt;

   assign slot_end = (presc == PRESC_LAST);
   assign wrap     = slot_end && (idx == IDX_LAST);

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_unpack
      assign in_nib[k] = data_in[4*k +: 4];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc       <= '0;
         idx         <= '0;
         pwm_cnt     <= '0;
         frame_start <= 1'b0;
      end else begin
         pwm_cnt     <= pwm_cnt + 1'b1;
         frame_start <= wrap;
         if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // A load landing on the wrap cycle bypasses pending and shows in the frame just starting.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_nib   <= '{default: '0};
         act_nib    <= '{default: '0};
         pend_en    <= '0;
         pend_pt    <= '0;
         act_en     <= '0;
         act_pt     <= '0;
         pend_valid <= 1'b0;
      end else if (load && wrap) begin
         act_nib    <= in_nib;
         act_en     <= digit_en;
         act_pt     <= digit_point;
         pend_valid <= 1'b0;
      end else begin
         if (wrap && pend_valid) begin
            act_nib <= pend_nib;
            act_en  <= pend_en;
            act_pt  <= pend_pt;
         end
         if (wrap) begin
            pend_valid <= 1'b0;
         end
         if (load) begin
            pend_nib   <= in_nib;
            pend_en    <= digit_en;
            pend_pt    <= digit_point;
            pend_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      lit         = act_en[idx] && ((pwm_cnt < brightness) || (&brightness));
      anode_nxt   = '1;
      segment_nxt = SEG_BLANK;
      if (lit) begin
         anode_nxt[idx]             = 1'b0;
         segment_nxt[SEG_G:SEG_A]   = hex_to_seg(act_nib[idx]);
         segment_nxt[SEG_DP]        = ~act_pt[idx];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         anode   <= '1;
         segment <= SEG_BLANK;
      end else begin
         anode   <= anode_nxt;
         segment <= segment_nxt;
      end
   end

endmodule

// File: tb/tb_seven_segment_mux.sv
// tb/tb_seven_segment_mux.sv - randomized scoreboard bench for seven_segment_mux
module tb_seven_segment_mux;

   localparam int ND    = 4;
   localparam int RD    = 4;
   localparam int FRAME = ND * RD;

   logic          clk = 1'b0;
   logic          resetn;
   logic [15:0]   data_in;
   logic [3:0]    digit_en;
   logic [3:0]    digit_point;
   logic          load;
   logic [3:0]    brightness;
   logic [3:0]    anode;
   logic [7:0]    segment;
   logic          frame_start;

   seven_segment_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(4)) dut (
      .clk(clk), .resetn(resetn), .data_in(data_in), .digit_en(digit_en),
      .digit_point(digit_point), .load(load), .brightness(brightness),
      .anode(anode), .segment(segment), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         t;
      logic [3:0] an;
      logic [7:0] seg;
      logic       fs;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Active-high gfedcba glyphs for 0-F
   logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [15:0] cur_data, nxt_data;
   logic [3:0]  cur_en, cur_pt, nxt_en, nxt_pt, bright;
   logic        m_pend;

   task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s t=%0d got=%h want=%h", name, t, act, want);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      check("one_anode_low", -1, 32'($countones(~anode) <= 1), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("anode", e.t, 32'(anode), 32'(e.an));
         check("segment", e.t, 32'(segment), 32'(e.seg));
         check("frame_start", e.t, 32'(frame_start), 32'(e.fs));
      end
   end

   // Drive the inputs for model cycle t and queue what the outputs must show one edge later.
   task automatic step(input int t, input int phase);
      int         idx, pwm, sel;
      logic       do_load, on;
      logic [3:0] nib;
      exp_t       e;
      if (t > 0 && t % FRAME == 0 && m_pend) begin
         cur_data = nxt_data;
         cur_en   = nxt_en;
         cur_pt   = nxt_pt;
         m_pend   = 1'b0;
      end
      sel = (t / 64) % 4;
      if (t < 64 || sel == 0)    bright = 4'hF;
      else if (sel == 1) begin
         if (t % 16 == 0)        bright = 4'($urandom_range(0, 15));
      end else if (sel == 2)     bright = 4'h0;
      else                       bright = 4'h4;

      do_load     = 1'b0;
      data_in     = 16'($urandom);
      digit_en    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      digit_point = 4'($urandom);
      if (phase == 1 && t == 2) begin
         do_load     = 1'b1;
         data_in     = 16'h1234;
         digit_en    = 4'hF;
         digit_point = 4'h0;
      end else if (t >= 32) begin
         do_load = ($urandom_range(0, 3) == 0) || (t % 64 == 47);
      end
      load       = do_load;
      brightness = bright;
      if (do_load) begin
         nxt_data = data_in;
         nxt_en   = digit_en;
         nxt_pt   = digit_point;
         m_pend   = 1'b1;
      end

      idx = (t / RD) % ND;
      pwm = t % 16;
      on  = (((cur_en >> idx) & 4'h1) != 0) && (bright == 4'hF || pwm < int'(bright));
      nib = 4'((cur_data >> (4 * idx)) & 16'hF);
      e.t   = t;
      e.an  = on ? (4'hF ^ 4'(1 << idx)) : 4'hF;
      e.seg = on ? {~(((cur_pt >> idx) & 4'h1) != 0), ~glyph_hi[nib]} : 8'hFF;
      e.fs  = (t % FRAME) == FRAME - 1;
      exp_q.push_back(e);
   endtask

   task automatic run_phase(input int cycles, input int phase);
      cur_data = '0; cur_en = '0; cur_pt = '0;
      nxt_data = '0; nxt_en = '0; nxt_pt = '0;
      m_pend   = 1'b0;
      bright   = 4'hF;
      for (int t = 0; t < cycles; t++) begin
         step(t, phase);
         @(negedge clk);
      end
   endtask

   initial begin
      resetn = 1'b0; load = 1'b0; data_in = '0; digit_en = '0;
      digit_point = '0; brightness = 4'hF;
      repeat (3) @(negedge clk);
      check("rst_anode", 0, 32'(anode), 32'hF);
      check("rst_segment", 0, 32'(segment), 32'hFF);
      check("rst_frame_start", 0, 32'(frame_start), 32'h0);
      resetn = 1'b1;
      run_phase(403, 1);

      #2 resetn = 1'b0;
      #1;
      check("async_rst_anode", -1, 32'(anode), 32'hF);
      check("async_rst_segment", -1, 32'(segment), 32'hFF);
      check("async_rst_frame_start", -1, 32'(frame_start), 32'h0);
      repeat (3) @(negedge clk);
      check("hold_rst_anode", -1, 32'(anode), 32'hF);
      resetn = 1'b1;
      run_phase(300, 2);

      check("queue_drained", -1, 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
